tick_pwm: RTL and testbench

//  Tick-driven PWM generator that sits directly downstream of the divide-by-N strobe FSM.
//  - Advances only on cycles where the input strobe `tick` is high, typically one pulse

---
 rtl/tick_pwm.sv | 147 ++++++++++++++
 tb/tb_tick_pwm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_pwm.sv
// Tick-driven PWM generator with double-buffered duty/period, applied at period boundaries.
// Optional TICK_PWM_PERIOD_CNT_EN adds a saturating completed-period counter port.
module tick_pwm #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] duty_in,
  input  logic [W-1:0] period_in,
  output logic         load_ack,
  output logic         pwm_out,
  output logic         period_end,
  output logic         busy
`ifdef TICK_PWM_PERIOD_CNT_EN
  ,
  output logic [W-1:0] period_count
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] duty_a_q, duty_a_d;
  logic [W-1:0] period_a_q, period_a_d;
  logic [W-1:0] duty_sh_q, duty_sh_d;
  logic [W-1:0] period_sh_q, period_sh_d;
  logic         pending_q, pending_d;
  logic         load_ack_q, load_ack_d;
  logic         pwm_q, pwm_d;
  logic         period_end_q, period_end_d;
  logic         copy;

`ifdef TICK_PWM_PERIOD_CNT_EN
  logic [W-1:0] period_count_q, period_count_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    duty_a_d     = duty_a_q;
    period_a_d   = period_a_q;
    period_end_d = 1'b0;
    copy         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StRun;
          cnt_d   = '0;
          copy    = pending_q;
        end
      end
      StRun, StStop: begin
        // RUN/STOP only differ in whether the period will repeat; tracked every clk.
        state_d = enable ? StRun : StStop;
        if (tick) begin
          if (cnt_q == period_a_q) begin
            cnt_d        = '0;
            period_end_d = 1'b1;
            copy         = pending_q;
            state_d      = enable ? StRun : StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (copy) begin
      duty_a_d   = duty_sh_q;
      period_a_d = period_sh_q;
    end

    // A coincident load re-arms pending after the boundary consumed the old shadow.
    pending_d   = (pending_q && !copy) || load;
    duty_sh_d   = load ? duty_in : duty_sh_q;
    period_sh_d = load ? period_in : period_sh_q;
    load_ack_d  = load;

    pwm_d = (state_d != StIdle) && (cnt_d < duty_a_d);
  end

`ifdef TICK_PWM_PERIOD_CNT_EN
  always_comb begin
    period_count_d = period_count_q;
    if (load && (state_q == StIdle)) begin
      period_count_d = '0;
    end else if (period_end_d && (period_count_q != '1)) begin
      period_count_d = period_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_count_q <= '0;
    end else begin
      period_count_q <= period_count_d;
    end
  end

  assign period_count = period_count_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      duty_a_q     <= '0;
      period_a_q   <= '0;
      duty_sh_q    <= '0;
      period_sh_q  <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      duty_a_q     <= duty_a_d;
      period_a_q   <= period_a_d;
      duty_sh_q    <= duty_sh_d;
      period_sh_q  <= period_sh_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tick_pwm.sv
// Self-checking bench for tick_pwm: directed vector table, corner sequences, and a random
// run compared against a tick-level behavioural model.
module tb_tick_pwm;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, tick, enable, load;
  logic [W-1:0] duty_in, period_in;
  logic         load_ack, pwm_out, period_end, busy;
`ifdef TICK_PWM_PERIOD_CNT_EN
  logic [W-1:0] period_count;
`endif

  tick_pwm #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .enable     (enable),
    .load       (load),
    .duty_in    (duty_in),
    .period_in  (period_in),
    .load_ack   (load_ack),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .busy       (busy)
`ifdef TICK_PWM_PERIOD_CNT_EN
    ,
    .period_count (period_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hi_cnt = 0;

  // Behavioural model: "running" covers both RUN and STOP.
  bit          m_run;
  int unsigned m_pos, m_duty, m_per, m_sh_duty, m_sh_per, m_count;
  bit          m_pend, m_ack, m_pe, m_pwm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clk(input bit r, input bit t, input bit e, input bit l,
                           input int unsigned di, input int unsigned pi);
    bit was_running;
    if (r) begin
      m_run = 0; m_pos = 0; m_duty = 0; m_per = 0; m_sh_duty = 0; m_sh_per = 0;
      m_pend = 0; m_ack = 0; m_pe = 0; m_pwm = 0; m_count = 0;
      return;
    end
    was_running = m_run;
    m_pe  = 0;
    m_ack = l;
    if (t) begin
      if (!m_run) begin
        if (e) begin
          m_run = 1;
          m_pos = 0;
          if (m_pend) begin m_duty = m_sh_duty; m_per = m_sh_per; m_pend = 0; end
        end
      end else if (m_pos == m_per) begin
        m_pe  = 1;
        m_pos = 0;
        if (m_count < 255) m_count++;
        if (m_pend) begin m_duty = m_sh_duty; m_per = m_sh_per; m_pend = 0; end
        m_run = e;
      end else begin
        m_pos++;
      end
    end
    if (l) begin
      if (!was_running) m_count = 0;
      m_sh_duty = di;
      m_sh_per  = pi;
      m_pend    = 1;
    end
    m_pwm = m_run && (m_pos < m_duty);
  endtask

  task automatic step();
    bit r, t, e, l;
    int unsigned di, pi;
    r = reset; t = tick; e = enable; l = load; di = duty_in; pi = period_in;
    @(posedge clk);
    model_clk(r, t, e, l, di, pi);
    #1;
    chk("pwm_out", pwm_out, m_pwm);
    chk("load_ack", load_ack, m_ack);
    chk("period_end", period_end, m_pe);
    chk("busy", busy, m_run);
`ifdef TICK_PWM_PERIOD_CNT_EN
    chk("period_count", period_count, m_count);
`endif
    if (pwm_out === 1'b1) hi_cnt++;
  endtask

  task automatic cyc(input bit r, input bit t, input bit e, input bit l,
                     input int unsigned di, input int unsigned pi);
    reset = r; tick = t; enable = e; load = l;
    duty_in = W'(di); period_in = W'(pi);
    step();
  endtask

  // One tick followed by two idle clks, mirroring a divide-by-3 strobe.
  task automatic tick3(input bit e, input bit l, input int unsigned di, input int unsigned pi);
    cyc(0, 1, e, l, di, pi);
    cyc(0, 0, e, 0, di, pi);
    cyc(0, 0, e, 0, di, pi);
  endtask

  typedef struct {
    bit          rst, tk, en, ld;
    int unsigned duty, per;
    bit          pwm, ack, pe, bsy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    reset = 1; tick = 0; enable = 0; load = 0; duty_in = '0; period_in = '0;

    // Reset with tick toggling, then basic duty=1 period=2 run, hand-derived.
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 2, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
    vecs[4]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};

    #2;
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].tk, vecs[i].en, vecs[i].ld, vecs[i].duty, vecs[i].per);
      chk($sformatf("vec%0d.pwm", i), pwm_out, vecs[i].pwm);
      chk($sformatf("vec%0d.ack", i), load_ack, vecs[i].ack);
      chk($sformatf("vec%0d.pe", i), period_end, vecs[i].pe);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
    end

    // Double buffering: duty 1 -> 2 loaded mid-period takes effect next period.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 2);
    tick3(1, 0, 0, 0);
    tick3(1, 0, 0, 0);
    cyc(0, 0, 1, 1, 2, 2);
    hi_cnt = 0;
    tick3(1, 0, 0, 0);
    chk("dbuf_cur_high", hi_cnt, 0);
    hi_cnt = 0;
    repeat (3) tick3(1, 0, 0, 0);
    chk("dbuf_next_high", hi_cnt, 6);

    // Stop at cnt=0 of a period=3 run: three more ticks, then the boundary.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 3);
    tick3(1, 0, 0, 0);
    repeat (3) tick3(0, 0, 0, 0);
    chk("stop_busy", busy, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("stop_pe", period_end, 1);
    chk("stop_idle", busy, 0);
    chk("stop_pwm", pwm_out, 0);
    repeat (2) tick3(0, 0, 0, 0);
    chk("stop_ignored", busy, 0);

    // duty=0 never drives high.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 3);
    hi_cnt = 0;
    repeat (12) tick3(1, 0, 0, 0);
    chk("duty0_high", hi_cnt, 0);

    // duty > period: constant high; then a load on the boundary tick lands one period later.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 3);
    hi_cnt = 0;
    repeat (13) tick3(1, 0, 0, 0);
    chk("duty9_high", hi_cnt, 39);
    repeat (3) tick3(1, 0, 0, 0);
    hi_cnt = 0;
    tick3(1, 1, 0, 3);
    repeat (3) tick3(1, 0, 0, 0);
    chk("bound_load_old", hi_cnt, 12);
    hi_cnt = 0;
    repeat (4) tick3(1, 0, 0, 0);
    chk("bound_load_new", hi_cnt, 0);

    // Reset mid-run with a pending load: everything clears, pending is lost.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 3);
    repeat (6) tick3(1, 0, 0, 0);
    cyc(0, 0, 1, 1, 7, 3);
    cyc(1, 1, 1, 0, 0, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pe", period_end, 0);
    chk("rst_ack", load_ack, 0);
    hi_cnt = 0;
    repeat (4) tick3(1, 0, 0, 0);
    chk("rst_noload_high", hi_cnt, 0);
`ifdef TICK_PWM_PERIOD_CNT_EN
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_period_count", period_count, 0);
`endif

    // Randomized run against the model.
    begin
      bit en_r = 1;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 24) == 0) en_r = ~en_r;
        cyc(($urandom_range(0, 299) == 0), (($urandom_range(0, 2) == 0) || (n % 3 == 0)),
            en_r, ($urandom_range(0, 11) == 0), $urandom_range(0, 9),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 5));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
